// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush controller for the 5-stage 64-bit pipeline. It decides,
// every cycle, which pipeline registers load, which load a bubble, and where
// the PC comes from. It also keeps saturating event counters and a sticky
// memory-timeout flag.
//
// Event priority: taken branch > memory wait > load-use (load-use only in RUN).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   IDrs1, IDrs2, IDuses_rs2 source registers of the instruction in ID
//   IDEXMR, IDEXWN           MemRead / destination of the instruction in EX
//   MEMBranch, MEMzero       branch resolution in MEM
//   MEMMR, MEMMW, MEMbusy    data-memory access in MEM and its wait state
//   PCSrc, PCWrite           PC source select and PC update enable
//   *Write / *Flush          per pipeline-register load enable / bubble insert
//   stall_cnt, wait_cnt,     saturating event counters (load-use stall cycles,
//   flush_cnt                memory-wait cycles, taken branches)
//   mem_timeout              sticky: TIMEOUT consecutive memory-wait cycles
//   state                    current FSM state (RUN=0, WAIT=1, FLUSH=2)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       IDrs1,
   input  logic [4:0]       IDrs2,
   input  logic             IDuses_rs2,
   input  logic             IDEXMR,
   input  logic [4:0]       IDEXWN,
   input  logic             MEMBranch,
   input  logic             MEMzero,
   input  logic             MEMMR,
   input  logic             MEMMW,
   input  logic             MEMbusy,
   output logic             PCSrc,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IFIDFlush,
   output logic             IDEXWrite,
   output logic             IDEXFlush,
   output logic             EXMEMWrite,
   output logic             EXMEMFlush,
   output logic             MEMWBFlush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] wait_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             mem_timeout,
   output logic [1:0]       state
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   localparam int                RUN_W    = $clog2(TIMEOUT + 1);
   localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(TIMEOUT);
   localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(TIMEOUT - 1);

   // Increment that holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic             taken;
   logic             memwait;
   logic             lduse;
   logic             wait_act;
   logic             lduse_act;
   logic [1:0]       next_state;
   logic [RUN_W-1:0] run_len;

   always_comb begin
      taken   = MEMBranch & MEMzero;
      memwait = MEMbusy & (MEMMR | MEMMW);
      // Register 31 is XZR: writing it never creates a dependency.
      lduse   = IDEXMR & (IDEXWN != 5'd31) &
                ((IDEXWN == IDrs1) | (IDuses_rs2 & (IDEXWN == IDrs2)));

      wait_act = memwait & ~taken;
      // Load-use only acts from RUN; in FLUSH the ID stage holds a bubble and
      // in WAIT the release cycle behaves as a plain default cycle.
      lduse_act = lduse & ~taken & ~memwait & (state == ST_RUN);

      PCSrc      = taken;
      PCWrite    = ~wait_act & ~lduse_act;
      IFIDWrite  = ~wait_act & ~lduse_act;
      IFIDFlush  = taken;
      IDEXWrite  = ~wait_act;
      IDEXFlush  = taken | lduse_act;
      EXMEMWrite = ~wait_act;
      EXMEMFlush = taken;
      MEMWBFlush = wait_act;

      if (taken)        next_state = ST_FLUSH;
      else if (memwait) next_state = ST_WAIT;
      else              next_state = ST_RUN;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_RUN;
         stall_cnt   <= '0;
         wait_cnt    <= '0;
         flush_cnt   <= '0;
         run_len     <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state <= next_state;
         if (lduse_act) stall_cnt <= sat_inc(stall_cnt);
         if (wait_act)  wait_cnt  <= sat_inc(wait_cnt);
         if (taken)     flush_cnt <= sat_inc(flush_cnt);

         // Watchdog: run length of consecutive memwait cycles, held at
         // TIMEOUT once reached; the flag sets on the cycle the run hits it.
         if (memwait) begin
            if (run_len != RUN_MAX) run_len <= run_len + 1'b1;
            if (run_len >= RUN_LAST) mem_timeout <= 1'b1;
         end else begin
            run_len <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

   localparam int CNT_W   = 6;
   localparam int TIMEOUT = 16;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic [4:0]       IDrs1, IDrs2, IDEXWN;
   logic             IDuses_rs2, IDEXMR, MEMBranch, MEMzero, MEMMR, MEMMW, MEMbusy;
   logic             PCSrc, PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush;
   logic             EXMEMWrite, EXMEMFlush, MEMWBFlush, mem_timeout;
   logic [CNT_W-1:0] stall_cnt, wait_cnt, flush_cnt;
   logic [1:0]       state;

   pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .IDrs1(IDrs1), .IDrs2(IDrs2), .IDuses_rs2(IDuses_rs2),
      .IDEXMR(IDEXMR), .IDEXWN(IDEXWN),
      .MEMBranch(MEMBranch), .MEMzero(MEMzero),
      .MEMMR(MEMMR), .MEMMW(MEMMW), .MEMbusy(MEMbusy),
      .PCSrc(PCSrc), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
      .IDEXWrite(IDEXWrite), .IDEXFlush(IDEXFlush),
      .EXMEMWrite(EXMEMWrite), .EXMEMFlush(EXMEMFlush), .MEMWBFlush(MEMWBFlush),
      .stall_cnt(stall_cnt), .wait_cnt(wait_cnt), .flush_cnt(flush_cnt),
      .mem_timeout(mem_timeout), .state(state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected view of one cycle: control bits ordered
   // {PCSrc,PCWrite,IFIDWrite,IFIDFlush,IDEXWrite,IDEXFlush,EXMEMWrite,EXMEMFlush,MEMWBFlush}
   typedef struct {
      logic [8:0] ctl;
      int         st;
      int         stall;
      int         wt;
      int         fl;
      int         to;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model: state is derived from what happened last cycle
   int m_prev_taken, m_prev_wait, m_stall, m_wait, m_flush, m_run, m_to;

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic model_reset();
      m_prev_taken = 0; m_prev_wait = 0;
      m_stall = 0; m_wait = 0; m_flush = 0; m_run = 0; m_to = 0;
   endtask

   task automatic step(input logic [4:0] a_rs1, input logic [4:0] a_rs2, input logic a_u2,
                       input logic a_exmr, input logic [4:0] a_wn, input logic a_br,
                       input logic a_z, input logic a_mr, input logic a_mw,
                       input logic a_busy, input logic a_rst);
      int   tk, mwt, lu, st, lact, hold;
      exp_t e;
      @(negedge clk);
      IDrs1 = a_rs1; IDrs2 = a_rs2; IDuses_rs2 = a_u2; IDEXMR = a_exmr; IDEXWN = a_wn;
      MEMBranch = a_br; MEMzero = a_z; MEMMR = a_mr; MEMMW = a_mw; MEMbusy = a_busy;
      if (a_rst) begin
         #1 rst = 1'b1;
         model_reset();
      end else begin
         rst = 1'b0;
      end
      tk  = int'(a_br && a_z);
      mwt = int'(a_busy && (a_mr || a_mw));
      lu  = int'(a_exmr && a_wn != 5'd31 && (a_wn == a_rs1 || (a_u2 && a_wn == a_rs2)));
      st  = m_prev_taken ? 2 : (m_prev_wait ? 1 : 0);
      hold = int'(mwt != 0 && tk == 0);
      lact = int'(lu != 0 && tk == 0 && mwt == 0 && st == 0);
      e.ctl = {tk[0], ~(hold[0] | lact[0]), ~(hold[0] | lact[0]), tk[0],
               ~hold[0], tk[0] | lact[0], ~hold[0], tk[0], hold[0]};
      e.st = st; e.stall = m_stall; e.wt = m_wait; e.fl = m_flush; e.to = m_to;
      q.push_back(e);
      if (!a_rst) begin
         if (lact != 0) m_stall = sat(m_stall);
         if (hold != 0) m_wait  = sat(m_wait);
         if (tk != 0)   m_flush = sat(m_flush);
         m_run = (mwt != 0) ? m_run + 1 : 0;
         if (m_run >= TIMEOUT) m_to = 1;
         m_prev_taken = tk;
         m_prev_wait  = mwt;
      end
   endtask

   task automatic idle();
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check(input string name, input int act, input int expv);
      if (act != expv) begin
         miscompares++;
         $display("FAIL %s at vector %0d: got %0d, expected %0d", name, vectors, act, expv);
      end
   endtask

   // Monitor: outputs are valid every cycle, sampled mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (q.size() != 0) begin
            e = q.pop_front();
            vectors++;
            check("ctl", int'({PCSrc, PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush,
                               EXMEMWrite, EXMEMFlush, MEMWBFlush}), int'(e.ctl));
            check("state", int'(state), e.st);
            check("stall_cnt", int'(stall_cnt), e.stall);
            check("wait_cnt", int'(wait_cnt), e.wt);
            check("flush_cnt", int'(flush_cnt), e.fl);
            check("mem_timeout", int'(mem_timeout), e.to);
         end
      end
   end

   initial begin
      int guard;
      logic [4:0] r1, r2, wn;
      rst = 1'b1;
      IDrs1 = '0; IDrs2 = '0; IDuses_rs2 = 0; IDEXMR = 0; IDEXWN = '0;
      MEMBranch = 0; MEMzero = 0; MEMMR = 0; MEMMW = 0; MEMbusy = 0;
      model_reset();

      step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1'b1);   // reset state
      idle();
      // load-use on rs1, then XZR destination
      step(5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, 0, 0, 0);
      idle();
      step(5'd31, 5'd0, 0, 1, 5'd31, 0, 0, 0, 0, 0, 0);
      // rs2 gating
      step(5'd1, 5'd7, 0, 1, 5'd7, 0, 0, 0, 0, 0, 0);
      step(5'd1, 5'd7, 1, 1, 5'd7, 0, 0, 0, 0, 0, 0);
      idle();
      // taken branch, load-use during FLUSH, back to RUN
      step(5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 0, 0, 0);
      step(5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, 0, 0, 0);
      idle();
      // three-cycle memory wait
      repeat (3) step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, 0);
      idle();
      // taken together with memwait
      step(5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 1, 0, 1, 0);
      idle();
      // watchdog: 16 busy cycles on a store
      repeat (TIMEOUT) step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 0);
      idle();
      idle();
      // reset between edges in the middle of a wait
      repeat (3) step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, 0);
      step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, 1'b1);
      step(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 1, 0);
      idle();

      // randomized traffic, with counters small enough to saturate
      for (int i = 0; i < 600; i++) begin
         wn = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(1, 3));
         r1 = ($urandom_range(0, 6) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
         r2 = 5'($urandom_range(0, 3));
         step(r1, r2, 1'($urandom), 1'($urandom), wn,
              1'($urandom_range(0, 3) == 0), 1'($urandom),
              1'($urandom), 1'($urandom),
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 99) == 0));
      end

      guard = 0;
      while (q.size() != 0 && guard < 20) begin
         @(negedge clk);
         #5;
         guard++;
      end
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d vectors left unchecked, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage 64-bit pipeline.
- Sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Inputs: load-use hazards detected in ID, taken branches resolved in MEM, and data-memory wait states.
- Outputs: per-register write-enable and bubble-insert controls, the PC source select, and saturating event counters plus a memory-timeout flag.

Parameters:
- CNT_W, 32, width of each event counter.
- TIMEOUT, 16, consecutive memory-wait cycles after which mem_timeout sets.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- IDrs1  in  5  rs1 field of the instruction in ID.
- IDrs2  in  5  rs2 field of the instruction in ID.
- IDuses_rs2  in  1  ID instruction reads rs2.
- IDEXMR  in  1  MemRead of the instruction in EX.
- IDEXWN  in  5  destination register of the instruction in EX.
- MEMBranch  in  1  branch flag in the MEM stage.
- MEMzero  in  1  zero flag in the MEM stage.
- MEMMR  in  1  MemRead in the MEM stage.
- MEMMW  in  1  MemWrite in the MEM stage.
- MEMbusy  in  1  data memory not ready this cycle.
- PCSrc  out  1  select branch target for the PC.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID load enable.
- IFIDFlush  out  1  IF/ID load bubble.
- IDEXWrite  out  1  ID/EX load enable.
- IDEXFlush  out  1  ID/EX load bubble (control bits zero).
- EXMEMWrite  out  1  EX/MEM load enable.
- EXMEMFlush  out  1  EX/MEM load bubble.
- MEMWBFlush  out  1  MEM/WB load bubble.
- stall_cnt  out  CNT_W  load-use stall cycles.
- wait_cnt  out  CNT_W  memory-wait cycles.
- flush_cnt  out  CNT_W  taken branches.
- mem_timeout  out  1  sticky: memory wait exceeded TIMEOUT.
- state  out  2  current FSM state, for debug.

Behaviour:
- Event terms:
  - taken = MEMBranch & MEMzero.
  - memwait = MEMbusy & (MEMMR | MEMMW).
  - lduse = IDEXMR & (IDEXWN != 31) & ((IDEXWN == IDrs1) | (IDuses_rs2 & IDEXWN == IDrs2)).
  - Register 31 is XZR and never hazards.
- FSM states (encoding): RUN=0, WAIT=1, FLUSH=2.
- Priority in any state: taken > memwait > lduse (lduse only in RUN).
- Output rules, all combinational from state and current inputs:
  - Default: all Write=1, all Flush=0, PCSrc=0.
  - taken: PCSrc=1; IFIDFlush=IDEXFlush=EXMEMFlush=1; Writes stay 1. Next state FLUSH.
  - memwait (not taken): PCWrite=IFIDWrite=IDEXWrite=EXMEMWrite=0; MEMWBFlush=1. Next state WAIT. Remains WAIT while memwait; returns to RUN the first cycle memwait=0, and that cycle follows the default rules.
  - lduse in RUN (no taken, no memwait): PCWrite=IFIDWrite=0, IDEXFlush=1. State stays RUN; condition clears naturally next cycle.
  - In FLUSH: lduse ignored (ID holds a bubble). Returns to RUN after exactly one cycle unless taken or memwait applies.
- Counters, saturating at all-ones:
  - stall_cnt +1 per cycle the lduse action applies.
  - wait_cnt +1 per WAIT-action cycle.
  - flush_cnt +1 per taken cycle.
- Memory watchdog:
  - An internal run-length counter counts consecutive memwait cycles and clears when memwait=0.
  - When the run length reaches TIMEOUT, mem_timeout sets, is sticky, and clears only on rst.
- Reset (asynchronous, any time including mid-WAIT/FLUSH):
  - state=RUN, all counters 0, mem_timeout=0.
  - Outputs take default values immediately, since they are combinational from state and inputs.
- Latency: all control outputs are same-cycle (combinational); counters and flag update at the next rising edge.

Test Plan:
- Load-use: IDEXMR=1, IDEXWN=5, IDrs1=5. Expect PCWrite=0, IFIDWrite=0, IDEXFlush=1 for 1 cycle; stall_cnt 0→1. Repeat with IDEXWN=31: no stall.
- rs2 gating: IDEXWN=7, IDrs2=7. With IDuses_rs2=0 expect no stall; with IDuses_rs2=1 expect stall.
- Taken branch: MEMBranch=1, MEMzero=1. Expect PCSrc=1 and all three Flush=1 that cycle; state=FLUSH next cycle; flush_cnt=1. A simultaneous lduse in the FLUSH cycle causes no stall; state is RUN the following cycle.
- Memory wait: MEMMR=1, MEMbusy=1 for 3 cycles. Expect all Writes 0 and MEMWBFlush=1 for 3 cycles; wait_cnt=3; default outputs on the 4th cycle.
- Priority and timeout:
  - taken with memwait together → flush behaviour wins.
  - MEMbusy held 16 cycles with MEMMW=1 → mem_timeout=1 and stays 1 after busy drops.
- Async reset: assert rst mid-WAIT between clock edges. Expect state=RUN, counters 0 and mem_timeout 0 immediately; outputs revert to the memwait/default rules from current inputs.
